// File: rtl/x16_pkg.sv
// Shared types and constants for the 16x16 product accumulator.
// Optional saturation is selected by the macro X16_PROD_ACCU_SAT_EN.
package x16_pkg;

   localparam int PROD_W    = 32;
   localparam int ACC_W_DEF = 36;
   localparam int LEN_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/x16_accu_add.sv
// Accumulator adder: acc + zero-extended product, wrapping by default or
// saturating to all ones with a carry flag when X16_PROD_ACCU_SAT_EN is defined.
module x16_accu_add
   import x16_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [PROD_W-1:0] prod_i,
   output logic [ACC_W-1:0]  sum_o,
   output logic              ovf_o
);

   logic [ACC_W-1:0] prodExt;

   assign prodExt = {{(ACC_W-PROD_W){1'b0}}, prod_i};

`ifdef X16_PROD_ACCU_SAT_EN
   logic [ACC_W:0] fullSum;

   // Once saturated, acc is all ones, so every later add either carries again
   // or adds zero; the value therefore stays pinned for the rest of the run.
   assign fullSum = {1'b0, acc_i} + {1'b0, prodExt};
   assign ovf_o   = fullSum[ACC_W];
   assign sum_o   = fullSum[ACC_W] ? {ACC_W{1'b1}} : fullSum[ACC_W-1:0];
`else
   assign sum_o = acc_i + prodExt;
   assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/x16_prod_accu.sv
// Sums LEN products from a 16x16 multiplier and hands the total out with a
// valid/ready handshake. Saturation enabled by macro X16_PROD_ACCU_SAT_EN.
module x16_prod_accu
   import x16_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod,
   output logic              prod_ready,
   output logic              res_valid,
   output logic [ACC_W-1:0]  res,
   input  logic              res_ready,
   output logic              busy,
   output logic              ovf
);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] addSum;
   logic             addOvf;

   x16_accu_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .acc_i  (acc_q),
      .prod_i (prod),
      .sum_o  (addSum),
      .ovf_o  (addOvf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               len_d   = len;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = (len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            // len_q is nonzero here, so cnt never counts past len_q.
            if (prod_valid) begin
               acc_d = addSum;
               cnt_d = cnt_q + LEN_W'(1);
               ovf_d = ovf_q | addOvf;
               if (cnt_q == len_q - LEN_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign prod_ready = (state_q == ACCUM);
   assign res_valid  = (state_q == DONE);
   assign res        = (state_q == DONE) ? acc_q : '0;
   assign busy       = (state_q != IDLE);
   assign ovf        = ovf_q;

endmodule
